// File: rtl/step_input_ctrl_pkg.sv
// Shared types and constants for the step/clear button front end.
package step_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STEP,
    CLEARING
  } ctrl_state_t;

  localparam int ADDBY_W = 4;

endpackage

// File: rtl/step_input_ctrl_button_debounce.sv
// Two-flop synchroniser plus counter-based debouncer for one raw button.
// rise is a registered one-cycle pulse on each debounced 0->1 transition;
// releases are filtered the same way but produce no pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic clear,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_d, stable_q;
  logic             rise_d, rise_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Metastability filter; carries no state worth resetting
  always_ff @(posedge clock) begin
    sync1_q <= raw;
    sync2_q <= sync1_q;
  end

  // Count consecutive disagreeing cycles; flip the stable value on the last one
  always_comb begin
    stable_d = stable_q;
    rise_d   = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register
  always_ff @(posedge clock) begin
    if (clear) begin
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/step_input_ctrl.sv
// Button/switch front end for the Counter: turns a debounced step press into
// one step pulse with a freshly sampled addBy, and a debounced clear press
// into a CLEAR_HOLD-cycle low pulse on clear_n.
// Optional feature macro: STEP_AUTO_REPEAT_EN (auto-repeat while step held).
module step_input_ctrl
  import step_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CLEAR_HOLD      = 2,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               btn_step_raw,
  input  logic               btn_clear_raw,
  input  logic [ADDBY_W-1:0] sw_addby,
  output logic [ADDBY_W-1:0] addBy,
  output logic               step,
  output logic               clear_n,
  output logic               busy
);

  localparam int HOLD_W = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLEAR_HOLD - 1);

  // Reject parameter values the counters cannot represent
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (CLEAR_HOLD < 1) begin : g_bad_hold
    $error("CLEAR_HOLD must be at least 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  logic [ADDBY_W-1:0] sw_sync1_q, sw_sync2_q;
  logic               step_stable, step_rise;
  logic               clear_stable, clear_rise;
  logic               step_go;
  logic               unused_stable;

  ctrl_state_t        state_d, state_q;
  logic [HOLD_W-1:0]  hold_d, hold_q;
  logic               pending_d, pending_q;
  logic [ADDBY_W-1:0] addby_d, addby_q;
  logic               step_d, step_q;
  logic               clear_n_d, clear_n_q;

  // Switch synchroniser, bitwise two-flop, not reset
  always_ff @(posedge clock) begin
    sw_sync1_q <= sw_addby;
    sw_sync2_q <= sw_sync1_q;
  end

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clock  (clock),
    .clear  (clear),
    .raw    (btn_step_raw),
    .stable (step_stable),
    .rise   (step_rise)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clock  (clock),
    .clear  (clear),
    .raw    (btn_clear_raw),
    .stable (clear_stable),
    .rise   (clear_rise)
  );

  // Only the edges drive the FSM; the levels matter just for auto-repeat
  assign unused_stable = step_stable ^ clear_stable;

`ifdef STEP_AUTO_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_d, rpt_q;
  logic             rpt_fire;

  // Count idle cycles with step held; fire a synthetic press at the interval
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if ((state_q == IDLE) && step_stable) begin
      if (rpt_q == RPT_LAST) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  // Repeat counter register
  always_ff @(posedge clock) begin
    if (clear) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end

  assign step_go = step_rise | rpt_fire;
`else
  assign step_go = step_rise;
`endif

  // Next-state logic; clear beats step, clears seen mid-step are parked in pending
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    addby_d   = addby_q;
    case (state_q)
      IDLE: begin
        if (clear_rise || pending_q) begin
          state_d   = CLEARING;
          hold_d    = '0;
          pending_d = 1'b0;
        end else if (step_go) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        addby_d = sw_sync2_q;
        state_d = STEP;
        if (clear_rise) pending_d = 1'b1;
      end
      STEP: begin
        state_d = IDLE;
        if (clear_rise) pending_d = 1'b1;
      end
      CLEARING: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = CLEARING;
        hold_d  = '0;
      end
    endcase
    step_d    = (state_d == STEP);
    clear_n_d = (state_d != CLEARING);
  end

  // Control and output registers; reset lands in CLEARING so clear_n stays low afterwards
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= CLEARING;
      hold_q    <= '0;
      pending_q <= 1'b0;
      addby_q   <= '0;
      step_q    <= 1'b0;
      clear_n_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      addby_q   <= addby_d;
      step_q    <= step_d;
      clear_n_q <= clear_n_d;
    end
  end

  assign addBy   = addby_q;
  assign step    = step_q;
  assign clear_n = clear_n_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_step_input_ctrl.sv
// Directed bench for step_input_ctrl with DEBOUNCE_CYCLES=4, CLEAR_HOLD=2,
// REPEAT_CYCLES=8. Expected addBy values are queued when a press is driven
// and popped whenever the DUT emits a step pulse.
module tb_step_input_ctrl;

  logic       clock = 1'b0;
  logic       clear;
  logic       btn_step_raw;
  logic       btn_clear_raw;
  logic [3:0] sw_addby;
  logic [3:0] addBy;
  logic       step;
  logic       clear_n;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0] exp_q[$];
  logic [3:0] counter_model;

  always #5 clock = ~clock;

  step_input_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CLEAR_HOLD      (2),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clock         (clock),
    .clear         (clear),
    .btn_step_raw  (btn_step_raw),
    .btn_clear_raw (btn_clear_raw),
    .sw_addby      (sw_addby),
    .addBy         (addBy),
    .step          (step),
    .clear_n       (clear_n),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Downstream Counter model fed by the DUT outputs
  always @(posedge clock) begin
    if (!clear_n) counter_model <= 4'h0;
    else if (step) counter_model <= counter_model + addBy;
  end

  // Scoreboard: every step pulse consumes one expected addBy
  always @(negedge clock) begin
    if (step === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_step", {31'b0, step}, 32'h0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("step_addby", {28'b0, addBy}, {28'b0, e});
      end
    end
  end

  function automatic logic exp_held_step(input int i);
`ifdef STEP_AUTO_REPEAT_EN
    return (i == 8) || (i == 18) || (i == 28);
`else
    return (i == 8);
`endif
  endfunction

  initial begin
    int low_cnt;
    clear         = 1'b1;
    btn_step_raw  = 1'b0;
    btn_clear_raw = 1'b0;
    sw_addby      = 4'h0;

    // 1: reset held 3 cycles, then clear_n low for 2 more
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_addby", {28'b0, addBy}, 32'h0);
      chk("rst_step", {31'b0, step}, 32'h0);
      chk("rst_clear_n", {31'b0, clear_n}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h1);
    end
    clear = 1'b0;
    tick();
    chk("post_rst_clear_n_low", {31'b0, clear_n}, 32'h0);
    chk("post_rst_busy", {31'b0, busy}, 32'h1);
    tick();
    chk("post_rst_clear_n_high", {31'b0, clear_n}, 32'h1);
    chk("post_rst_idle", {31'b0, busy}, 32'h0);

    // 2: held press, step exactly at edge 8 with addBy=7
    sw_addby     = 4'h7;
    btn_step_raw = 1'b1;
    exp_q.push_back(4'h7);
`ifdef STEP_AUTO_REPEAT_EN
    exp_q.push_back(4'h7);
    exp_q.push_back(4'h7);
`endif
    for (int i = 1; i <= 28; i++) begin
      tick();
      chk("held_step_timing", {31'b0, step}, {31'b0, exp_held_step(i)});
      if (i == 7) chk("addby_before_load", {28'b0, addBy}, 32'h0);
      if (i == 8) chk("addby_at_step", {28'b0, addBy}, 32'h7);
    end
    btn_step_raw = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("held_idle_after", {31'b0, busy}, 32'h0);

    // 3: 2-cycle glitch is filtered
    btn_step_raw = 1'b1;
    tick();
    tick();
    btn_step_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch_busy", {31'b0, busy}, 32'h0);
    end
    chk("glitch_addby", {28'b0, addBy}, 32'h7);

    // 4: simultaneous clear and step, clear wins
    btn_step_raw  = 1'b1;
    btn_clear_raw = 1'b1;
    low_cnt = 0;
    for (int i = 1; i <= 22; i++) begin
      if (i == 11) begin
        btn_step_raw  = 1'b0;
        btn_clear_raw = 1'b0;
      end
      tick();
      if (clear_n == 1'b0) low_cnt++;
    end
    chk("both_clear_n_low_cycles", low_cnt, 32'd2);
    chk("both_addby", {28'b0, addBy}, 32'h7);
    chk("both_busy", {31'b0, busy}, 32'h0);

    // 5: three clean presses accumulate into the Counter
    begin
      logic [3:0] vals [3];
      vals[0] = 4'hF;
      vals[1] = 4'h1;
      vals[2] = 4'h8;
      for (int k = 0; k < 3; k++) begin
        sw_addby     = vals[k];
        btn_step_raw = 1'b1;
        exp_q.push_back(vals[k]);
        for (int i = 0; i < 10; i++) tick();
        chk("press_addby", {28'b0, addBy}, {28'b0, vals[k]});
        btn_step_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
      end
    end
    chk("counter_total", {28'b0, counter_model}, 32'h8);
    chk("press_busy", {31'b0, busy}, 32'h0);

    // Clear press lands during LOAD: step completes, then clear is taken
    sw_addby     = 4'h3;
    btn_step_raw = 1'b1;
    exp_q.push_back(4'h3);
    tick();
    btn_clear_raw = 1'b1;
    for (int i = 2; i <= 13; i++) begin
      tick();
      if (i == 8) chk("pend_step", {31'b0, step}, 32'h1);
      if (i == 9) chk("pend_clear_n_9", {31'b0, clear_n}, 32'h1);
      if (i == 10) chk("pend_clear_n_10", {31'b0, clear_n}, 32'h0);
      if (i == 11) chk("pend_clear_n_11", {31'b0, clear_n}, 32'h0);
      if (i == 12) chk("pend_clear_n_12", {31'b0, clear_n}, 32'h1);
    end
    chk("pend_addby", {28'b0, addBy}, 32'h3);
    btn_step_raw  = 1'b0;
    btn_clear_raw = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Reset mid-operation (in LOAD): held button re-debounces afterwards
    sw_addby     = 4'h5;
    btn_step_raw = 1'b1;
    exp_q.push_back(4'h5);
    for (int i = 1; i <= 7; i++) tick();
    chk("mid_busy_load", {31'b0, busy}, 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("mid_rst_addby", {28'b0, addBy}, 32'h0);
    chk("mid_rst_step", {31'b0, step}, 32'h0);
    chk("mid_rst_clear_n", {31'b0, clear_n}, 32'h0);
    for (int i = 9; i <= 16; i++) begin
      tick();
      if (i == 9) chk("mid_clear_n_9", {31'b0, clear_n}, 32'h0);
      if (i == 10) chk("mid_clear_n_10", {31'b0, clear_n}, 32'h1);
      chk("mid_step_timing", {31'b0, step}, {31'b0, (i == 14)});
    end
    btn_step_raw = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
